// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates reqN, computes the result in the grant cycle and
// holds it for the owner until consumed. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic        rsp0_c,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic        rsp1_c,
    output logic        busy
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // reqN_ready is combinational, rspN_valid/out/c are registered and held until rspN_ready.
    typedef enum logic {IDLE, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q;
    logic [31:0] res_q;
    logic        c_q;
    logic        rsp_hs;
    logic        can_grant;
    logic        grant;
    logic        grant_id;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] alu_res;
    logic        alu_c;
    logic [4:0]  sh;
    logic        lts, ltu;

    assign rsp_hs    = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    assign can_grant = !rst && ((state_q == IDLE) || rsp_hs);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant_id = !req0_valid;
`else
    logic last_q;
    // On a tie the requester that did not win last time goes first.
    assign grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
`endif

    assign grant      = can_grant && (req0_valid || req1_valid);
    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant && grant_id;

    assign op  = grant_id ? req1_op : req0_op;
    assign a   = grant_id ? req1_a : req0_a;
    assign b   = grant_id ? req1_b : req0_b;
    assign sh  = b[4:0];
    assign lts = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        alu_res = 32'd0;
        alu_c   = 1'b0;
        case (op)
            4'd0:  alu_res = a + b;
            4'd1:  alu_res = a - b;
            4'd2:  alu_res = a << sh;
            4'd3:  alu_res = {31'd0, lts};
            4'd4:  alu_res = {31'd0, ltu};
            4'd5:  alu_res = a ^ b;
            4'd6:  alu_res = a >> sh;
            4'd7:  alu_res = $signed(a) >>> sh;
            4'd8:  alu_res = a | b;
            4'd9:  alu_res = a & b;
            4'd10: alu_c = (a == b);
            4'd11: alu_c = (a != b);
            4'd12: alu_c = lts;
            4'd13: alu_c = !lts;
            4'd14: alu_c = ltu;
            default: alu_c = !ltu;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (grant)
            state_d = RESP;
        else if (rsp_hs)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            res_q   <= 32'd0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_id;
                res_q   <= alu_res;
                c_q     <= alu_c;
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b1;
        else if (grant)
            last_q <= grant_id;
    end
`endif

    assign busy       = (state_q == RESP);
    assign rsp0_valid = busy && !owner_q;
    assign rsp1_valid = busy && owner_q;
    assign rsp0_out   = rsp0_valid ? res_q : 32'd0;
    assign rsp1_out   = rsp1_valid ? res_q : 32'd0;
    assign rsp0_c     = rsp0_valid && c_q;
    assign rsp1_c     = rsp1_valid && c_q;

endmodule
